// File: rtl/serializer_arbiter.sv
// serializer_arbiter: round-robin scheduler that shares one 8-bit LSB-first
// serializer among N_REQ byte requesters. It captures the winning byte,
// pulses the serializer load, and then waits out the serializer's 8-bit shift
// window plus its idle edge before it arbitrates again.
//
// Handshake: req[i] is a level held until gnt[i] pulses. gnt[i] means data[i]
// was captured on that edge. data[i] may change from the cycle after gnt[i].
module serializer_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   data,
  output logic [N_REQ-1:0]     gnt,
  output logic                 ser_load,
  output logic [7:0]           ser_in,
  output logic                 busy,
  output logic [ID_W-1:0]      cur_id,
  output logic                 frame_done,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    FLUSH = 2'd0,
    IDLE  = 2'd1,
    LOAD  = 2'd2,
    SHIFT = 2'd3
  } state_t;

  // Both FLUSH and SHIFT span 9 edges (cnt 0..8).
  localparam logic [3:0]      LAST_CNT = 4'd8;
  localparam logic [ID_W-1:0] RST_ID   = ID_W'(N_REQ - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              ser_load_q, ser_load_d;
  logic [7:0]        ser_in_q, ser_in_d;
  logic              busy_q, busy_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic              frame_done_q, frame_done_d;

  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   cand;
  logic [7:0]        win_byte;
  logic              arb;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(cur_id_q) + k) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Byte of the selected requester.
  always_comb begin
    win_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_id == ID_W'(i)) win_byte = data[8*i +: 8];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt_d        = '0;
    ser_load_d   = 1'b0;
    ser_in_d     = ser_in_q;
    busy_d       = busy_q;
    cur_id_d     = cur_id_q;
    frame_done_d = 1'b0;
    arb          = 1'b0;

    case (state_q)
      FLUSH: begin
        // The serializer has no reset; let any byte in flight drain out.
        busy_d = 1'b0;
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      IDLE: begin
        arb = 1'b1;
      end
      LOAD: begin
        // The serializer captures ser_in on this edge.
        cnt_d   = 4'd0;
        state_d = SHIFT;
        busy_d  = 1'b1;
      end
      SHIFT: begin
        if (cnt_q == LAST_CNT) begin
          // Serializer idle edge: window over, safe to load again.
          frame_done_d = 1'b1;
          cnt_d        = 4'd0;
          arb          = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = FLUSH;
        cnt_d   = 4'd0;
      end
    endcase

    if (arb) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      if (en && win_found) begin
        state_d         = LOAD;
        busy_d          = 1'b1;
        gnt_d[win_id]   = 1'b1;
        ser_load_d      = 1'b1;
        ser_in_d        = win_byte;
        cur_id_d        = win_id;
      end
    end
  end

  // State and output registers; reset restarts the drain sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FLUSH;
      cnt_q        <= 4'd0;
      gnt_q        <= '0;
      ser_load_q   <= 1'b0;
      ser_in_q     <= 8'h00;
      busy_q       <= 1'b0;
      cur_id_q     <= RST_ID;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      ser_load_q   <= ser_load_d;
      ser_in_q     <= ser_in_d;
      busy_q       <= busy_d;
      cur_id_q     <= cur_id_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign gnt        = gnt_q;
  assign ser_load   = ser_load_q;
  assign ser_in     = ser_in_q;
  assign busy       = busy_q;
  assign cur_id     = cur_id_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_serializer_arbiter.sv
// Testbench for serializer_arbiter: random requesters against a frame-level
// reference model; expected grants and frame ends go into queues that a
// negedge monitor drains.
module tb_serializer_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int W     = 32;

  // Clock and reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                en   = 1'b0;
  logic [N_REQ-1:0]    req  = '0;
  logic [8*N_REQ-1:0]  data = '0;
  logic [N_REQ-1:0]    gnt;
  logic                ser_load;
  logic [7:0]          ser_in;
  logic                busy;
  logic [ID_W-1:0]     cur_id;
  logic                frame_done;
  logic [1:0]          dbg_state;

  serializer_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req        (req),
    .data       (data),
    .gnt        (gnt),
    .ser_load   (ser_load),
    .ser_in     (ser_in),
    .busy       (busy),
    .cur_id     (cur_id),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Scoreboard: {cycle[31:12], id[11:8], byte[7:0]}
  logic [W-1:0] exp_q[$];
  int           fd_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference model. A frame occupies the grant edge plus 10 more edges; the
  // last of those is the frame end and also the next arbitration point.
  // After reset, 9 edges are ignored before arbitration begins.
  int m_flush = 9;
  int m_wait  = 0;
  int m_cur   = N_REQ - 1;
  bit m_busy  = 1'b0;
  int mj;
  int mk;
  bit m_found;
  bit m_arb;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_flush = 9;
      m_wait  = 0;
      m_cur   = N_REQ - 1;
      m_busy  = 1'b0;
      exp_q.delete();
      fd_q.delete();
    end else if (m_flush > 0) begin
      m_flush--;
    end else begin
      m_arb = 1'b1;
      if (m_wait > 0) begin
        m_wait--;
        m_arb = (m_wait == 0);
        if (m_arb) fd_q.push_back(cyc);
      end
      if (m_arb) begin
        m_busy  = 1'b0;
        m_found = 1'b0;
        mj      = 0;
        if (en) begin
          for (mk = 1; mk <= N_REQ; mk++) begin
            if (!m_found && req[(m_cur + mk) % N_REQ]) begin
              m_found = 1'b1;
              mj      = (m_cur + mk) % N_REQ;
            end
          end
        end
        if (m_found) begin
          exp_q.push_back({cyc[19:0], 4'(mj), data[mj*8 +: 8]});
          m_cur  = mj;
          m_wait = 10;
          m_busy = 1'b1;
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the model every cycle.
  logic         exp_load;
  logic         exp_fd;
  logic [W-1:0] e;

  always @(negedge clk) begin
    exp_load = (exp_q.size() > 0) && (exp_q[0][31:12] == cyc[19:0]);
    check("ser_load", {31'd0, ser_load}, {31'd0, exp_load});
    check("gnt_any", {31'd0, |gnt}, {31'd0, exp_load});
    if (exp_load) begin
      e = exp_q.pop_front();
      check("gnt_onehot", {28'd0, gnt}, 32'd1 << e[11:8]);
      check("ser_in", {24'd0, ser_in}, {24'd0, e[7:0]});
    end
    exp_fd = (fd_q.size() > 0) && (fd_q[0] == cyc);
    check("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
    if (exp_fd) void'(fd_q.pop_front());
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("cur_id", {30'd0, cur_id}, m_cur);
  end

  // Driver: one cycle of requester behaviour, applied at the falling edge.
  task automatic drive_cycle(input int p_raise, input int p_drop, input int p_keep, input bit en_rand);
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i[ID_W-1:0]]) begin
        if (int'($urandom_range(0, 99)) >= p_keep) req[i[ID_W-1:0]] = 1'b0;
        data[i*8 +: 8] = 8'($urandom);
      end else if (!req[i[ID_W-1:0]]) begin
        if (int'($urandom_range(0, 99)) < p_raise) begin
          data[i*8 +: 8]     = 8'($urandom);
          req[i[ID_W-1:0]]   = 1'b1;
        end
      end else if (int'($urandom_range(0, 99)) < p_drop) begin
        req[i[ID_W-1:0]] = 1'b0;
      end
    end
    if (en_rand && $urandom_range(0, 99) < 5) en = ~en;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, {28'd0, gnt}, 32'd0);
    check({tag, "_ser_load"}, {31'd0, ser_load}, 32'd0);
    check({tag, "_ser_in"}, {24'd0, ser_in}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_cur_id"}, {30'd0, cur_id}, N_REQ - 1);
  endtask

  initial begin
    // Reset held for a few cycles
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    // Single request from requester 0 with byte A5
    en         = 1'b1;
    data[7:0]  = 8'hA5;
    req        = 4'b0001;
    rst_n      = 1'b1;
    repeat (30) drive_cycle(0, 0, 0, 1'b0);

    // All requesters continuously: strict 0,1,2,3,0 rotation, 10 cycles apart
    @(negedge clk);
    req = 4'b1111;
    repeat (60) drive_cycle(0, 0, 100, 1'b0);
    @(negedge clk);
    req = '0;
    repeat (15) drive_cycle(0, 0, 0, 1'b0);

    // Random traffic with en toggling and requests withdrawn before grant
    repeat (1500) drive_cycle(20, 2, 30, 1'b1);

    // Reset pulse in the middle of a frame with all requests held
    @(negedge clk);
    en  = 1'b1;
    req = 4'b1111;
    for (int t = 0; t < 200 && !(busy && dbg_state == 2'd3); t++) drive_cycle(0, 0, 100, 1'b0);
    check("reached_shift", {30'd0, dbg_state}, 32'd3);
    repeat (3) drive_cycle(0, 0, 100, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) drive_cycle(0, 0, 100, 1'b0);

    // More random traffic
    repeat (500) drive_cycle(25, 3, 40, 1'b1);

    // Drain: everything outstanding must have been observed
    @(negedge clk);
    req = '0;
    en  = 1'b0;
    repeat (30) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 32'd0);
    check("fd_q_empty", fd_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
